fft_frame_feeder: RTL

Frame source for the forward xfft input channel: captures one frame of ADC samples on a start edge, then streams it as a single AXI4-Stream frame. It drives s_axis_data_tdata, s_axis_data_tvalid and s_axis_data_tlast, honours s_axis_data_tready, and replaces a free-running tvalid tie. It sits between the ADC interface and the FFT/complex-multiply/IFFT chain, so every transform receives exactly FRAME_LEN beats with a correctly placed tlast.

---
 rtl/fft_frame_feeder.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/fft_frame_feeder.sv
// ============================================================================
// fft_frame_feeder
// ----------------------------------------------------------------------------
// Frame source for the forward xfft input channel. A rising edge on `start`
// arms a capture of FRAME_LEN ADC samples into an internal frame buffer; the
// buffered frame is then streamed out as one AXI4-Stream packet with tlast on
// the final beat. In continuous mode the block re-arms itself after every
// frame and flags any sample it had to drop while streaming.
//
// Optional feature (compile-time macro):
//   FFT_FEEDER_DC_REMOVE_EN  defined   -> real = ad_data - 2^(DATA_W-1),
//                                         sign-extended to 16 bits
//                            undefined -> real = ad_data zero-extended
//
// Parameters:
//   FRAME_LEN  samples per frame (power of two, equals the xfft point size)
//   LOG2_LEN   log2(FRAME_LEN); width of the address counters and sample_idx
//   DATA_W     ADC sample width (less than 16)
//
// Ports:
//   fft_clk        clock for every register in the block
//   sys_rst_n      asynchronous, active-low reset
//   ad_data        ADC sample, offset binary
//   ad_valid       one-cycle strobe marking ad_data as a new sample
//   start          level input; a rising edge arms a capture
//   continuous     1 = re-arm automatically after each frame is sent
//   m_axis_tdata   {imag[15:0], real[15:0]}; imag is always zero
//   m_axis_tvalid  AXI-Stream valid
//   m_axis_tready  AXI-Stream ready (xfft s_axis_data_tready)
//   m_axis_tlast   high while beat FRAME_LEN-1 is presented
//   busy           high while capturing or sending
//   frame_done     one-cycle pulse after the last beat is accepted
//   overrun        sticky: a sample was dropped during SEND in continuous mode
//   sample_idx     capture write address, or index of the presented beat
// ============================================================================
module fft_frame_feeder #(
    parameter int FRAME_LEN = 1024,
    parameter int LOG2_LEN  = 10,
    parameter int DATA_W    = 10
) (
    input  logic                fft_clk,
    input  logic                sys_rst_n,
    input  logic [DATA_W-1:0]   ad_data,
    input  logic                ad_valid,
    input  logic                start,
    input  logic                continuous,
    output logic [31:0]         m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
    output logic                busy,
    output logic                frame_done,
    output logic                overrun,
    output logic [LOG2_LEN-1:0] sample_idx
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SEND,
        ST_DONE
    } state_t;

    localparam logic [LOG2_LEN-1:0] LAST_ADDR = LOG2_LEN'(FRAME_LEN - 1);
    localparam logic [LOG2_LEN-1:0] ADDR_ONE  = LOG2_LEN'(1);

    state_t              state;
    state_t              state_nxt;

    // Start edge detection
    logic                start_q;
    logic                edge_armed;
    logic                start_edge;

    // Capture side
    logic [LOG2_LEN-1:0] wr_addr;
    logic                wr_en;
    logic [15:0]         sample_conv;

    // Stream side: the output register doubles as the RAM read register, so a
    // beat is fetched straight into the presented slot whenever the slot is
    // empty or is being emptied by a handshake in the same cycle.
    logic [LOG2_LEN-1:0] rd_addr;
    logic                rd_all;
    logic [LOG2_LEN-1:0] beat_idx;
    logic [15:0]         out_real;
    logic                out_valid;
    logic                out_last;
    logic                load;
    logic                beat_hs;
    logic                last_hs;

    logic [15:0]         frame_ram [FRAME_LEN];

    // ------------------------------------------------------------------------
    // Sample conversion
    // ------------------------------------------------------------------------
`ifdef FFT_FEEDER_DC_REMOVE_EN
    // Subtracting half scale from an offset-binary code is the same as
    // flipping its MSB; the result is then a two's-complement value.
    logic [DATA_W-1:0] centred;
    assign centred     = {~ad_data[DATA_W-1], ad_data[DATA_W-2:0]};
    assign sample_conv = 16'($signed(centred));
`else
    assign sample_conv = 16'(ad_data);
`endif

    // ------------------------------------------------------------------------
    // Control strobes
    // ------------------------------------------------------------------------
    // start_q resets low, so a start level already high at reset release would
    // look like an edge; edge_armed masks that first cycle out of reset.
    assign start_edge = start & ~start_q & edge_armed;
    assign wr_en      = (state == ST_CAPTURE) && ad_valid;
    assign beat_hs    = (state == ST_SEND) && out_valid && m_axis_tready;
    assign last_hs    = beat_hs && out_last;
    assign load       = (state == ST_SEND) && !rd_all && (!out_valid || m_axis_tready);

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    // NOTE: every clocked process uses non-blocking assignments so all
    // registers update together from the values present before the edge.
    always_ff @(posedge fft_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and state-decoded outputs
    // ------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        sample_idx = '0;
        case (state)
            ST_IDLE: begin
                if (start_edge) begin
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                busy       = 1'b1;
                sample_idx = wr_addr;
                if (wr_en && (wr_addr == LAST_ADDR)) begin
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                busy       = 1'b1;
                sample_idx = beat_idx;
                if (last_hs) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = continuous ? ST_CAPTURE : ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Capture address, start edge register and status flags
    // ------------------------------------------------------------------------
    always_ff @(posedge fft_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            start_q    <= 1'b0;
            edge_armed <= 1'b0;
            wr_addr    <= '0;
            overrun    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            start_q    <= start;
            edge_armed <= 1'b1;
            frame_done <= last_hs;
            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        wr_addr <= '0;
                        overrun <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    // The write of the last sample wraps the address to 0.
                    if (ad_valid) begin
                        wr_addr <= wr_addr + ADDR_ONE;
                    end
                end
                ST_SEND: begin
                    if (ad_valid && continuous) begin
                        overrun <= 1'b1;
                    end
                end
                ST_DONE: begin
                    wr_addr <= '0;
                end
                default: begin
                    wr_addr <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Frame buffer write port
    // ------------------------------------------------------------------------
    // NOTE: the frame buffer has no reset; every location is written during
    // CAPTURE before it is ever read, and leaving it unreset lets it map onto
    // block RAM.
    always_ff @(posedge fft_clk) begin
        if (wr_en) begin
            frame_ram[wr_addr] <= sample_conv;
        end
    end

    // ------------------------------------------------------------------------
    // Stream read side: synchronous RAM read into the presented beat
    // ------------------------------------------------------------------------
    always_ff @(posedge fft_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_addr   <= '0;
            rd_all    <= 1'b0;
            beat_idx  <= '0;
            out_real  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (state != ST_SEND) begin
            rd_addr   <= '0;
            rd_all    <= 1'b0;
            beat_idx  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_real  <= frame_ram[rd_addr];
            out_valid <= 1'b1;
            out_last  <= (rd_addr == LAST_ADDR);
            beat_idx  <= rd_addr;
            rd_addr   <= rd_addr + ADDR_ONE;
            rd_all    <= (rd_addr == LAST_ADDR);
        end else if (beat_hs) begin
            // Only the final beat can be accepted without a refill.
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    assign m_axis_tdata  = {16'h0000, out_real};
    assign m_axis_tvalid = out_valid;
    assign m_axis_tlast  = out_last;

    // ------------------------------------------------------------------------
    // Stream protocol properties
    // ------------------------------------------------------------------------
    a_stall_stable : assert property (
        @(posedge fft_clk) disable iff (!sys_rst_n)
        (m_axis_tvalid && !m_axis_tready) |=>
            (m_axis_tvalid && $stable(m_axis_tdata) && $stable(m_axis_tlast))
    );

    a_last_has_valid : assert property (
        @(posedge fft_clk) disable iff (!sys_rst_n)
        m_axis_tlast |-> m_axis_tvalid
    );

endmodule
